exe_muldiv_stage: RTL and testbench
===================================

# exe_muldiv_stage

Parametrised execute stage with a handshaked pipeline interface, N-source operand forwarding, and an iterative multiply/divide unit that owns the HI/LO pair. It sits between decode and the memory stage. It accepts one operation per cycle when free and stalls upstream while a multi-cycle MULT/DIV is in flight. It also holds its result register while the memory stage back-pressures.

## Interface
- DATA_W, 32: operand/result width (even, ≥8).
- REG_AW, 5: register-address width.
- NUM_FWD, 2: number of forwarding sources; index 0 has highest priority.
- SH_W, $clog2(DATA_W): shift-amount width.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  stage accepts this cycle.
- in_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 MULT, 11 MULTU, 12 DIV, 13 DIVU, 14 MFHI, 15 MFLO.
- in_src_a / in_src_b  in  REG_AW  source register numbers.
- in_opa / in_opb  in  DATA_W  register-file operand values.
- in_shamt  in  SH_W  shift amount.
- in_dst  in  REG_AW  destination register.
- in_regwrite  in  1  op writes a register.
- fwd_valid  in  NUM_FWD  forwarding source i holds a valid pending write.
- fwd_reg  in  NUM_FWD*REG_AW  destination of source i (slice i).
- fwd_data  in  NUM_FWD*DATA_W  value of source i.
- out_valid  out  1  result register holds an op.
- out_ready  in  1  downstream takes it.
- out_result  out  DATA_W  result.
- out_dst  out  REG_AW  destination.
- out_regwrite  out  1  write enable for result.
- busy  out  1  MULT/DIV in flight.

## Operation
- Forwarding, per operand: the operand is replaced by fwd_data[i] for the lowest i where fwd_valid[i] is set, fwd_reg[i] equals the source register, and the source register is nonzero. Otherwise in_opa or in_opb is used unchanged. Register 0 is never forwarded.
- Accept occurs when in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Single-cycle ops (0–9, 14, 15): the result is loaded into the output register on the accept edge.
  - out_regwrite = in_regwrite.
  - SLT and SLTU produce 1 or 0.
  - Shifts use in_shamt on operand B.
  - Arithmetic wraps modulo 2^DATA_W.
  - MFHI and MFLO return the current HI and LO.
- MULT/MULTU/DIV/DIVU capture the forwarded operands on accept and enter the MULDIV state.
  - The datapath is radix-2 iterative (shift-add or restoring divide): one bit per cycle, exactly DATA_W cycles.
  - Signed ops take magnitudes, then fix the sign at the end.
  - MULT: {HI,LO} = 2·DATA_W-bit product.
  - DIV: LO = quotient truncated toward zero; HI = remainder, carrying the sign of the dividend.
  - Divide by zero: LO = all-ones, HI = dividend. No exception.
  - Signed MIN / −1: LO = MIN, HI = 0.
- On completion, HI and LO are updated. The output register is loaded with out_regwrite=0, out_result=LO, and out_dst=in_dst as captured. This is a retire token only.
- FSM states:
  - IDLE. On accepting MULDIV-class ops it moves to MULDIV.
  - MULDIV. Counts DATA_W cycles. On the last cycle it moves to DONE.
  - DONE. Writes HI/LO in the first DONE cycle. Loads the output when (!out_valid || out_ready), then returns to IDLE.
- busy = (state != IDLE).
- Output hold: when out_valid && !out_ready, all out_* signals are stable. The output clears to out_valid=0 when it is taken and nothing new is loaded.

## Timing
- Single-cycle op accepted at edge t: out_valid is high after edge t.
- Back-to-back single-cycle ops sustain 1 per cycle while out_ready=1.
- MULT/DIV accepted at edge t:
  - MULDIV runs over edges t+1…t+DATA_W.
  - HI/LO update and the output load happen at edge t+DATA_W+1 if the output slot is free.
  - Otherwise they wait in DONE.
  - in_ready stays low from after edge t until DONE exits.
- MFHI accepted on the cycle after DONE exit sees the new HI.
- Forwarding is purely combinational on the accept cycle. Values are never re-sampled afterwards.
- RESET, asynchronous at any time including mid-MULDIV:
  - state=IDLE, counter=0, HI=LO=0.
  - out_valid=0, out_result=0, out_dst=0, out_regwrite=0, busy=0.
  - The in-flight MULT/DIV is discarded.
  - in_ready=1 once RESET deasserts.

## Test plan
- ALU sweep: ADD 0x7FFFFFFF+1 -> out_result 0x80000000. SLT(−1,0) -> 1. SLTU(−1,0) -> 0. SRA 0x80000000 by 4 -> 0xF8000000. Each appears one cycle after accept.
- Forwarding priority: src_a=5 with fwd0=(5,0x11) and fwd1=(5,0x22), both valid -> 0x11. Drop fwd0 -> 0x22. src_a=0 with a matching forward -> in_opa used.
- MULT −3×7 -> after DATA_W+1 cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB, then MFHI/MFLO return them. in_ready is low throughout and busy is high.
- DIV −7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 5/0 -> LO=0xFFFFFFFF, HI=5. DIV 0x80000000/−1 -> LO=0x80000000, HI=0.
- Back-pressure: hold out_ready=0 for 3 cycles after an ADD -> outputs stable and in_ready=0. A DIV completing while the output is blocked waits in DONE until out_ready=1.
- Assert RESET at cycle 10 of a MULT -> all outputs 0 and HI=LO=0. A following MFLO returns 0.

Source files
------------

// File: rtl/exe_muldiv_stage.sv
// Execute stage: single-cycle ALU with N-source operand forwarding, plus an iterative
// radix-2 multiply/divide unit that owns HI/LO and stalls upstream while it runs.
module exe_muldiv_stage #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned REG_AW  = 5,
   parameter int unsigned NUM_FWD = 2,
   parameter int unsigned SH_W    = $clog2(DATA_W)
) (
   input  logic                        CLK,
   input  logic                        RESET,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [3:0]                  in_op,
   input  logic [REG_AW-1:0]           in_src_a,
   input  logic [REG_AW-1:0]           in_src_b,
   input  logic [DATA_W-1:0]           in_opa,
   input  logic [DATA_W-1:0]           in_opb,
   input  logic [SH_W-1:0]             in_shamt,
   input  logic [REG_AW-1:0]           in_dst,
   input  logic                        in_regwrite,
   input  logic [NUM_FWD-1:0]          fwd_valid,
   input  logic [NUM_FWD*REG_AW-1:0]   fwd_reg,
   input  logic [NUM_FWD*DATA_W-1:0]   fwd_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DATA_W-1:0]           out_result,
   output logic [REG_AW-1:0]           out_dst,
   output logic                        out_regwrite,
   output logic                        busy
);

   localparam int unsigned CNT_W = $clog2(DATA_W);

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_XOR   = 4'd4;
   localparam logic [3:0] OP_SLT   = 4'd5;
   localparam logic [3:0] OP_SLTU  = 4'd6;
   localparam logic [3:0] OP_SLL   = 4'd7;
   localparam logic [3:0] OP_SRL   = 4'd8;
   localparam logic [3:0] OP_SRA   = 4'd9;
   localparam logic [3:0] OP_MULT  = 4'd10;
   localparam logic [3:0] OP_MULTU = 4'd11;
   localparam logic [3:0] OP_DIV   = 4'd12;
   localparam logic [3:0] OP_DIVU  = 4'd13;
   localparam logic [3:0] OP_MFHI  = 4'd14;
   localparam logic [3:0] OP_MFLO  = 4'd15;

   typedef enum logic [1:0] {S_IDLE, S_MULDIV, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   hi_q, lo_q;
   logic [DATA_W-1:0]   opa_fwd, opb_fwd, alu_res;
   logic                accept, is_md, md_signed, neg_a, neg_b, done_load;

   // Multi-cycle unit: work_hi/work_lo hold product halves or remainder/quotient
   logic                md_div_q, neg_a_q, neg_b_q, b_zero_q;
   logic [DATA_W-1:0]   a_raw_q, opm_q, work_hi, work_lo;
   logic [REG_AW-1:0]   md_dst_q;
   logic [DATA_W-1:0]   step_hi, step_lo, hi_new, lo_new, q_fix, r_fix;
   logic [DATA_W:0]     mul_sum, div_sh;
   logic [2*DATA_W-1:0] prod, prod_fix;

   assign accept   = in_valid && in_ready;
   assign in_ready = (state_q == S_IDLE) && (!out_valid || out_ready);
   assign busy     = (state_q != S_IDLE);
   assign is_md    = (in_op == OP_MULT) || (in_op == OP_MULTU) || (in_op == OP_DIV) || (in_op == OP_DIVU);
   assign md_signed = (in_op == OP_MULT) || (in_op == OP_DIV);
   assign neg_a    = md_signed && opa_fwd[DATA_W-1];
   assign neg_b    = md_signed && opb_fwd[DATA_W-1];

   // Forwarding: walk from lowest priority up so source 0 wins
   always_comb begin
      opa_fwd = in_opa;
      opb_fwd = in_opb;
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
         if (fwd_valid[i] && (fwd_reg[i*REG_AW +: REG_AW] == in_src_a) && (in_src_a != '0))
            opa_fwd = fwd_data[i*DATA_W +: DATA_W];
         if (fwd_valid[i] && (fwd_reg[i*REG_AW +: REG_AW] == in_src_b) && (in_src_b != '0))
            opb_fwd = fwd_data[i*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      alu_res = '0;
      case (in_op)
         OP_ADD:  alu_res = opa_fwd + opb_fwd;
         OP_SUB:  alu_res = opa_fwd - opb_fwd;
         OP_AND:  alu_res = opa_fwd & opb_fwd;
         OP_OR:   alu_res = opa_fwd | opb_fwd;
         OP_XOR:  alu_res = opa_fwd ^ opb_fwd;
         OP_SLT:  alu_res = DATA_W'($signed(opa_fwd) < $signed(opb_fwd));
         OP_SLTU: alu_res = DATA_W'(opa_fwd < opb_fwd);
         OP_SLL:  alu_res = opb_fwd << in_shamt;
         OP_SRL:  alu_res = opb_fwd >> in_shamt;
         OP_SRA:  alu_res = $signed(opb_fwd) >>> in_shamt;
         OP_MFHI: alu_res = hi_q;
         OP_MFLO: alu_res = lo_q;
         default: alu_res = '0;
      endcase
   end

   // One radix-2 step: shift-add multiply or restoring divide
   always_comb begin
      mul_sum = {1'b0, work_hi} + {1'b0, (work_lo[0] ? opm_q : '0)};
      div_sh  = {work_hi, work_lo[DATA_W-1]};
      if (md_div_q) begin
         if (div_sh >= {1'b0, opm_q}) begin
            step_hi = div_sh[DATA_W-1:0] - opm_q;
            step_lo = {work_lo[DATA_W-2:0], 1'b1};
         end else begin
            step_hi = div_sh[DATA_W-1:0];
            step_lo = {work_lo[DATA_W-2:0], 1'b0};
         end
      end else begin
         step_hi = mul_sum[DATA_W:1];
         step_lo = {mul_sum[0], work_lo[DATA_W-1:1]};
      end
   end

   // Sign fix-up and divide-by-zero override
   always_comb begin
      prod     = {work_hi, work_lo};
      prod_fix = (neg_a_q ^ neg_b_q) ? -prod : prod;
      q_fix    = (neg_a_q ^ neg_b_q) ? -work_lo : work_lo;
      r_fix    = neg_a_q ? -work_hi : work_hi;
      if (!md_div_q) begin
         hi_new = prod_fix[2*DATA_W-1:DATA_W];
         lo_new = prod_fix[DATA_W-1:0];
      end else if (b_zero_q) begin
         hi_new = a_raw_q;
         lo_new = '1;
      end else begin
         hi_new = r_fix;
         lo_new = q_fix;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      done_load = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept && is_md) begin
               state_d = S_MULDIV;
               cnt_d   = '0;
            end
         end
         S_MULDIV: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
               state_d = S_DONE;
               cnt_d   = '0;
            end
         end
         S_DONE: begin
            if (!out_valid || out_ready) begin
               done_load = 1'b1;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         md_div_q <= 1'b0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         b_zero_q <= 1'b0;
         a_raw_q  <= '0;
         opm_q    <= '0;
         work_hi  <= '0;
         work_lo  <= '0;
         md_dst_q <= '0;
      end else if (accept && is_md) begin
         md_div_q <= (in_op == OP_DIV) || (in_op == OP_DIVU);
         neg_a_q  <= neg_a;
         neg_b_q  <= neg_b;
         b_zero_q <= (opb_fwd == '0);
         a_raw_q  <= opa_fwd;
         opm_q    <= neg_b ? -opb_fwd : opb_fwd;
         work_hi  <= '0;
         work_lo  <= neg_a ? -opa_fwd : opa_fwd;
         md_dst_q <= in_dst;
      end else if (state_q == S_MULDIV) begin
         work_hi  <= step_hi;
         work_lo  <= step_lo;
      end
   end

   // HI/LO rewrite in DONE is idempotent since the work registers are frozen there
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (state_q == S_DONE) begin
         hi_q <= hi_new;
         lo_q <= lo_new;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         out_valid    <= 1'b0;
         out_result   <= '0;
         out_dst      <= '0;
         out_regwrite <= 1'b0;
      end else if (accept && !is_md) begin
         out_valid    <= 1'b1;
         out_result   <= alu_res;
         out_dst      <= in_dst;
         out_regwrite <= in_regwrite;
      end else if (done_load) begin
         out_valid    <= 1'b1;
         out_result   <= lo_new;
         out_dst      <= md_dst_q;
         out_regwrite <= 1'b0;
      end else if (out_ready) begin
         out_valid    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_exe_muldiv_stage.sv
// Randomised bench for exe_muldiv_stage against a plain-arithmetic model of ALU, forwarding and HI/LO.
module tb_exe_muldiv_stage;
   localparam int unsigned W  = 32;
   localparam int unsigned RA = 5;
   localparam int unsigned NF = 2;
   localparam int unsigned SW = 5;

   logic             CLK = 1'b0;
   logic             RESET;
   logic             in_valid, in_ready, in_regwrite;
   logic [3:0]       in_op;
   logic [RA-1:0]    in_src_a, in_src_b, in_dst;
   logic [W-1:0]     in_opa, in_opb;
   logic [SW-1:0]    in_shamt;
   logic [NF-1:0]    fwd_valid;
   logic [NF*RA-1:0] fwd_reg;
   logic [NF*W-1:0]  fwd_data;
   logic             out_valid, out_ready, out_regwrite, busy;
   logic [W-1:0]     out_result;
   logic [RA-1:0]    out_dst;

   int errors = 0;
   int checks = 0;
   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;

   exe_muldiv_stage #(.DATA_W(W), .REG_AW(RA), .NUM_FWD(NF), .SH_W(SW)) dut (
      .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_src_a(in_src_a), .in_src_b(in_src_b), .in_opa(in_opa), .in_opb(in_opb),
      .in_shamt(in_shamt), .in_dst(in_dst), .in_regwrite(in_regwrite),
      .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_dst(out_dst), .out_regwrite(out_regwrite), .busy(busy)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // First valid forwarding source naming the register wins; r0 is never forwarded
   function automatic logic [W-1:0] pick(input logic [RA-1:0] src, input logic [W-1:0] rf);
      for (int i = 0; i < NF; i++)
         if (fwd_valid[i] && fwd_reg[i*RA +: RA] == src && src != 0)
            return fwd_data[i*W +: W];
      return rf;
   endfunction

   function automatic logic [W-1:0] alu_ref(input logic [3:0] op, input logic [W-1:0] a, b,
                                             input logic [SW-1:0] sh);
      longint sb;
      sb = longint'($signed(b));
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a & b;
         4'd3:  return a | b;
         4'd4:  return a ^ b;
         4'd5:  return (longint'($signed(a)) < sb) ? 1 : 0;
         4'd6:  return (a < b) ? 1 : 0;
         4'd7:  return b << sh;
         4'd8:  return b >> sh;
         4'd9:  return W'(sb >>> sh);
         4'd14: return m_hi;
         4'd15: return m_lo;
         default: return '0;
      endcase
   endfunction

   task automatic md_ref(input logic [3:0] op, input logic [W-1:0] a, b,
                         output logic [W-1:0] hi, output logic [W-1:0] lo);
      logic [63:0] p;
      longint q, r;
      if (op == 4'd10) begin
         p = 64'(longint'($signed(a)) * longint'($signed(b)));
         hi = p[63:32]; lo = p[31:0];
      end else if (op == 4'd11) begin
         p = {32'b0, a} * {32'b0, b};
         hi = p[63:32]; lo = p[31:0];
      end else if (b == 0) begin
         hi = a; lo = '1;
      end else if (op == 4'd12) begin
         q = longint'($signed(a)) / longint'($signed(b));
         r = longint'($signed(a)) % longint'($signed(b));
         hi = W'(r); lo = W'(q);
      end else begin
         hi = a % b; lo = a / b;
      end
   endtask

   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, b, input logic [SW-1:0] sh,
                        input logic [RA-1:0] dst, input logic rw, input logic [RA-1:0] sa, sb);
      int n;
      @(negedge CLK);
      in_op = op; in_opa = a; in_opb = b; in_shamt = sh; in_dst = dst;
      in_regwrite = rw; in_src_a = sa; in_src_b = sb; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge CLK);
         n++;
      end
      if (!in_ready) check("accept_timeout", 0, 1);
      @(posedge CLK);
      #1 in_valid = 1'b0;
   endtask

   task automatic run_alu(input logic [3:0] op, input logic [W-1:0] a, b, input logic [SW-1:0] sh,
                          input logic [RA-1:0] sa, sb);
      logic [W-1:0] exp;
      logic [RA-1:0] dst;
      logic rw;
      dst = RA'($urandom_range(0, 31));
      rw  = 1'($urandom_range(0, 1));
      exp = alu_ref(op, pick(sa, a), pick(sb, b), sh);
      issue(op, a, b, sh, dst, rw, sa, sb);
      check($sformatf("op%0d_valid", op), out_valid, 1);
      check($sformatf("op%0d_result", op), out_result, exp);
      check($sformatf("op%0d_dst", op), out_dst, dst);
      check($sformatf("op%0d_regwrite", op), out_regwrite, rw);
      check("ready_after_alu", in_ready, out_ready);
   endtask

   task automatic run_md(input logic [3:0] op, input logic [W-1:0] a, b, input logic [RA-1:0] sa, sb);
      logic [W-1:0] eh, el;
      logic [RA-1:0] dst;
      dst = RA'($urandom_range(0, 31));
      md_ref(op, pick(sa, a), pick(sb, b), eh, el);
      issue(op, a, b, 0, dst, 1'b1, sa, sb);
      check("md_busy", busy, 1);
      for (int k = 0; k < W; k++) begin
         @(posedge CLK);
         #1 check("md_in_ready_low", in_ready, 0);
      end
      @(posedge CLK);
      #1;
      check("md_out_valid", out_valid, 1);
      check("md_out_lo", out_result, el);
      check("md_out_dst", out_dst, dst);
      check("md_out_regwrite", out_regwrite, 0);
      check("md_busy_clear", busy, 0);
      m_hi = eh;
      m_lo = el;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
   endtask

   initial begin
      logic [W-1:0] hold_res;
      logic [RA-1:0] hold_dst;
      logic hold_rw;
      RESET = 1'b1; in_valid = 0; in_op = 0; in_opa = 0; in_opb = 0; in_shamt = 0;
      in_src_a = 0; in_src_b = 0; in_dst = 0; in_regwrite = 0;
      fwd_valid = 0; fwd_reg = 0; fwd_data = 0; out_ready = 1'b1;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_result", out_result, 0);
      check("rst_busy", busy, 0);
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
      #1 check("rst_in_ready", in_ready, 1);

      // Directed ALU sweep
      run_alu(4'd0, 32'h7FFF_FFFF, 32'h1, 0, 1, 2);
      check("add_wrap", out_result, 32'h8000_0000);
      run_alu(4'd5, 32'hFFFF_FFFF, 32'h0, 0, 1, 2);
      check("slt_neg", out_result, 1);
      run_alu(4'd6, 32'hFFFF_FFFF, 32'h0, 0, 1, 2);
      check("sltu_big", out_result, 0);
      run_alu(4'd9, 32'h0, 32'h8000_0000, 4, 1, 2);
      check("sra", out_result, 32'hF800_0000);

      // Forwarding priority and r0 exclusion
      fwd_valid = 2'b11; fwd_reg = {5'd5, 5'd5}; fwd_data = {32'h22, 32'h11};
      run_alu(4'd0, 32'hAAAA, 32'h0, 0, 5, 0);
      check("fwd_pri0", out_result, 32'h11);
      fwd_valid = 2'b10;
      run_alu(4'd0, 32'hAAAA, 32'h0, 0, 5, 0);
      check("fwd_pri1", out_result, 32'h22);
      fwd_valid = 2'b11; fwd_reg = {5'd5, 5'd0};
      run_alu(4'd0, 32'hAAAA, 32'h0, 0, 0, 0);
      check("fwd_r0", out_result, 32'hAAAA);
      fwd_valid = 0;

      // Directed MULT/DIV corner cases
      run_md(4'd10, 32'hFFFF_FFFD, 32'd7, 1, 2);
      run_alu(4'd14, 0, 0, 0, 0, 0);
      check("mult_hi", out_result, 32'hFFFF_FFFF);
      run_alu(4'd15, 0, 0, 0, 0, 0);
      check("mult_lo", out_result, 32'hFFFF_FFEB);
      run_md(4'd12, 32'hFFFF_FFF9, 32'd2, 1, 2);
      run_alu(4'd15, 0, 0, 0, 0, 0);
      check("div_q", out_result, 32'hFFFF_FFFD);
      run_alu(4'd14, 0, 0, 0, 0, 0);
      check("div_r", out_result, 32'hFFFF_FFFF);
      run_md(4'd13, 32'd5, 32'd0, 1, 2);
      run_alu(4'd15, 0, 0, 0, 0, 0);
      check("divu0_q", out_result, 32'hFFFF_FFFF);
      run_alu(4'd14, 0, 0, 0, 0, 0);
      check("divu0_r", out_result, 32'd5);
      run_md(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 1, 2);
      run_alu(4'd15, 0, 0, 0, 0, 0);
      check("divmin_q", out_result, 32'h8000_0000);
      run_alu(4'd14, 0, 0, 0, 0, 0);
      check("divmin_r", out_result, 32'h0);

      // Random back-to-back ALU ops with random forwarding
      for (int i = 0; i < 40; i++) begin
         logic [3:0] op;
         op = 4'($urandom_range(0, 9));
         fwd_valid = NF'($urandom);
         fwd_reg   = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
         fwd_data  = {32'($urandom), 32'($urandom)};
         run_alu(op, 32'($urandom), 32'($urandom), SW'($urandom),
                 RA'($urandom_range(0, 3)), RA'($urandom_range(0, 3)));
      end

      // Random MULT/DIV with readback
      for (int i = 0; i < 8; i++) begin
         logic [W-1:0] b;
         b = (i % 4 == 3) ? '0 : 32'($urandom);
         fwd_valid = NF'($urandom);
         fwd_reg   = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
         fwd_data  = {32'($urandom), 32'($urandom)};
         run_md(4'($urandom_range(10, 13)), 32'($urandom), b,
                RA'($urandom_range(0, 3)), RA'($urandom_range(0, 3)));
         fwd_valid = 0;
         run_alu(4'd14, 0, 0, 0, 0, 0);
         run_alu(4'd15, 0, 0, 0, 0, 0);
      end

      // Back-pressure on a single-cycle op
      drain();
      out_ready = 1'b0;
      run_alu(4'd0, 32'd100, 32'd23, 0, 0, 0);
      hold_res = out_result; hold_dst = out_dst; hold_rw = out_regwrite;
      check("bp_add", hold_res, 32'd123);
      for (int k = 0; k < 3; k++) begin
         @(posedge CLK);
         #1;
         check("bp_valid", out_valid, 1);
         check("bp_result", out_result, hold_res);
         check("bp_dst", out_dst, hold_dst);
         check("bp_regwrite", out_regwrite, hold_rw);
         check("bp_in_ready", in_ready, 0);
      end

      // DIV completing with downstream stalled holds its retire token
      drain();
      out_ready = 1'b0;
      run_md(4'd12, 32'd1000, 32'hFFFF_FFF9, 0, 0);
      for (int k = 0; k < 3; k++) begin
         @(posedge CLK);
         #1;
         check("bp_div_valid", out_valid, 1);
         check("bp_div_lo", out_result, m_lo);
         check("bp_div_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      run_alu(4'd14, 0, 0, 0, 0, 0);
      check("bp_div_hi", out_result, 32'd6);

      // Reset in the middle of a MULT
      run_md(4'd10, 32'hFFFF_FFFD, 32'd7, 0, 0);
      issue(4'd11, 32'h1234_5678, 32'h9ABC_DEF0, 0, 5'd9, 1'b1, 0, 0);
      repeat (10) @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b1;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_result", out_result, 0);
      check("mid_rst_dst", out_dst, 0);
      check("mid_rst_regwrite", out_regwrite, 0);
      check("mid_rst_busy", busy, 0);
      @(negedge CLK);
      RESET = 1'b0;
      #1 check("mid_rst_in_ready", in_ready, 1);
      m_hi = '0;
      m_lo = '0;
      run_alu(4'd15, 0, 0, 0, 0, 0);
      check("rst_lo_zero", out_result, 0);
      run_alu(4'd14, 0, 0, 0, 0, 0);
      check("rst_hi_zero", out_result, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
